// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared widths and state encoding for the data memory responder
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - MEM-stage load/store request/response bus (be port with DMEM_BYTE_ENABLE_EN)
interface data_mem_responder_if;
    import dmem_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              err;
    logic              busy;
`ifdef DMEM_BYTE_ENABLE_EN
    logic [3:0]        be;

    modport master (output req, we, addr, wdata, be, input rdata, ack, err, busy);
    modport slave  (input req, we, addr, wdata, be, output rdata, ack, err, busy);
`else
    modport master (output req, we, addr, wdata, input rdata, ack, err, busy);
    modport slave  (input req, we, addr, wdata, output rdata, ack, err, busy);
`endif

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word array, synchronous write, combinational read
// Byte-lane write enables exist only with DMEM_BYTE_ENABLE_EN.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_W-1:0]     wr_data,
`ifdef DMEM_BYTE_ENABLE_EN
    input  logic [3:0]            wr_be,
`endif
    output logic [DATA_W-1:0]     rd_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

`ifdef DMEM_BYTE_ENABLE_EN
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wr_data;
        end
    end
`endif

    assign rd_data = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle data memory slave with wait states and address checking
// Optional byte-enable stores: DMEM_BYTE_ENABLE_EN.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    dmem_state_t       state;
    dmem_state_t       state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              take;
    logic              enter_resp;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_legal;
    logic              arr_wr;
    logic [DATA_W-1:0] arr_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        take       = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    take = 1'b1;
                    if (WAIT_LD == '0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (take) begin
            cnt <= WAIT_LD;
        end else if (state == WAIT) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (take) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
        end
    end

    // With zero wait states the access happens on the sampling edge itself,
    // so the live bus values must be used before the latches have loaded.
    assign acc_we    = (state == IDLE) ? bus.we    : we_q;
    assign acc_addr  = (state == IDLE) ? bus.addr  : addr_q;
    assign acc_wdata = (state == IDLE) ? bus.wdata : wdata_q;
    assign acc_legal = (acc_addr[1:0] == 2'b00) &&
                       (acc_addr[ADDR_W-1:DEPTH_LOG2+2] == '0);

    // Reset coinciding with the access edge must suppress the write as well.
    assign arr_wr = enter_resp & acc_we & acc_legal & ~reset;

`ifdef DMEM_BYTE_ENABLE_EN
    logic [3:0] be_q;
    logic [3:0] acc_be;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            be_q <= '0;
        end else if (take) begin
            be_q <= bus.be;
        end
    end

    assign acc_be = (state == IDLE) ? bus.be : be_q;
`endif

    dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_wr),
        .idx     (acc_addr[DEPTH_LOG2+1:2]),
        .wr_data (acc_wdata),
`ifdef DMEM_BYTE_ENABLE_EN
        .wr_be   (acc_be),
`endif
        .rd_data (arr_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= enter_resp & ~acc_legal;
            if (enter_resp && !acc_we && acc_legal) begin
                rdata_q <= arr_rd;
            end
        end
    end

    assign bus.ack   = (state == RESP);
    assign bus.busy  = (state != IDLE);
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder: the slave end of the pipeline's MEM-stage load/store interface.
- Accepts one word request at a time over a req/ack handshake and inserts a configurable number of wait states.
- Performs the load or store against an internal word array and flags misaligned or out-of-range addresses.
- Enables the MEM stage to stall on slow memory instead of assuming single-cycle access.

Parameters:
- DEPTH_LOG2, 8, log2 of the number of 32-bit words in the array (256 words).
- WAIT_CYCLES, 2, wait states inserted between request acceptance and response (0..15).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  1  request; held high by the initiator until ack
- we  input  1  1 = store, 0 = load; sampled with req in IDLE
- addr  input  32  byte address; sampled with req in IDLE
- wdata  input  32  store data; sampled with req in IDLE
- rdata  output  32  load data; valid while ack=1, holds its value otherwise
- ack  output  1  single-cycle response strobe
- err  output  1  valid with ack; misaligned or out-of-range access
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: clock is clk; reset is asynchronous and active-high. On reset, state=IDLE and the wait counter is cleared. Outputs reset to rdata=0, ack=0, err=0, busy=0. Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if req=1 at a rising edge, latch we/addr/wdata and load the counter with WAIT_CYCLES. Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
- WAIT: the counter decrements every cycle. On the edge where counter==1, go to RESP.
- Access: performed on the edge entering RESP.
  - Store: writes the latched word if the address is legal.
  - Load: registers array[addr[DEPTH_LOG2+1:2]] into rdata.
- RESP: lasts exactly one cycle with ack=1, then returns to IDLE unconditionally.
- Latency: ack is high in cycle N+WAIT_CYCLES+1, where N is the cycle in which req is sampled in IDLE.
- Throughput: the initiator must drop req in the cycle after ack. A req still high in the cycle after RESP is treated as a new request.
- Legality:
  - err=1 if addr[1:0]!=0, or if addr[31:DEPTH_LOG2+2]!=0.
  - On err, no write occurs and rdata holds its previous value.
  - err is cleared with ack.
- Input changes while busy=1 are ignored; only the IDLE-sampled values are used.
- Store followed by load to the same address returns the new data, since the write commits before ack.
- Reset during WAIT aborts the access with no write committed. Reset on the RESP edge takes priority, so ack is not asserted.
- rdata is not updated on stores.

Optional Feature:
- Macro: DMEM_BYTE_ENABLE_EN.
- With the macro:
  - Adds port be input 4, sampled with req in IDLE.
  - Stores write only the bytes whose be bit is set; be[0] maps to bits 7:0.
  - be=4'b0000 on a store is a legal no-op, with ack and err=0.
  - Loads ignore be.
- Without the macro: no be port; stores write the full word.

Decomposition:
- Package dmem_pkg holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - DATA_W=32 and ADDR_W=32;
  - the width of the wait counter (4 bits).
- Sub-module dmem_array: synchronous single-port word array with write enable (and byte enables when the macro is defined). It is instantiated once; the FSM, counter, legality check and handshake remain in data_mem_responder.

Test Plan:
- Store 0xDEADBEEF to 0x10, then load 0x10 (WAIT_CYCLES=2): each ack arrives 3 cycles after req is sampled; load rdata=0xDEADBEEF, err=0.
- WAIT_CYCLES=0: back-to-back loads with req dropped after each ack: ack 1 cycle after sampling; busy high exactly one cycle per access.
- Load from 0x13 (misaligned) and from 0x400 (out of range, DEPTH_LOG2=8): ack with err=1; rdata unchanged; a prior store to the same word is not corrupted.
- Assert reset during WAIT of a store of 0x12345678 to 0x20: no ack; a subsequent load of 0x20 returns the pre-reset contents.
- Change addr/wdata/we while busy=1: the response uses the values sampled in IDLE only.
- With DMEM_BYTE_ENABLE_EN, word initially 0xFFFFFFFF: store 0x00AB00CD with be=4'b0101 reads back 0xFFABFFCD; be=0 leaves the word unchanged.
